// File: rtl/gb80_sequencer.sv
// GB80 instruction sequencer: fetch/decode/execute FSM driving register-file, ALU and memory strobes.
// Optional macro GB80_SEQ_WAIT_STATE_EN makes memory states stall on i_mem_ready; otherwise they last one cycle.
module gb80_sequencer #(
  parameter int OPCODE_TYPE_LENGTH = 4,
  parameter int ALU_OPCODE_WIDTH   = 3,
  parameter int ADDR_LENGTH        = 3,
  parameter int PC_ADDR            = 3
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [OPCODE_TYPE_LENGTH-1:0] i_opcode_type,
  input  logic [ALU_OPCODE_WIDTH-1:0]   i_alu_op,
  input  logic [ADDR_LENGTH-1:0]        i_addr_A,
  input  logic [ADDR_LENGTH-1:0]        i_addr_B,
  input  logic                          i_mem_ready,
  input  logic                          i_wake,
  output logic [ADDR_LENGTH-1:0]        o_register_file_addr,
  output logic                          o_register_file_wr,
  output logic                          o_register_file_rd,
  output logic                          o_register_file_addr_wr,
  output logic                          o_register_file_addr_rd,
  output logic                          o_tmp_reg_wr,
  output logic                          o_tmp_reg_rd,
  output logic                          o_accumulator_reg_wr,
  output logic [ALU_OPCODE_WIDTH-1:0]   o_alu_control,
  output logic                          o_alu_rd,
  output logic                          o_flags_reg_wr,
  output logic                          o_rd_mem,
  output logic                          o_wr_mem,
  output logic                          o_inst_reg_wr,
  output logic                          o_halted,
  output logic                          o_illegal
);

  typedef enum logic [3:0] {
    S_RESET       = 4'd0,
    S_IDLE        = 4'd1,
    S_F_PC_OUT    = 4'd2,
    S_F_PC_INC    = 4'd3,
    S_F_DECODE    = 4'd4,
    S_LDRR_TMP    = 4'd5,
    S_LDRR_WR     = 4'd6,
    S_LDRI_PC_OUT = 4'd7,
    S_LDRI_PC_INC = 4'd8,
    S_ALU_TMP     = 4'd9,
    S_ALU_EXEC    = 4'd10,
    S_HALT        = 4'd11
  } state_t;

  localparam logic [OPCODE_TYPE_LENGTH-1:0] OP_LDRR = OPCODE_TYPE_LENGTH'(0);
  localparam logic [OPCODE_TYPE_LENGTH-1:0] OP_LDRI = OPCODE_TYPE_LENGTH'(1);
  localparam logic [OPCODE_TYPE_LENGTH-1:0] OP_ALU  = OPCODE_TYPE_LENGTH'(2);
  localparam logic [OPCODE_TYPE_LENGTH-1:0] OP_NOP  = OPCODE_TYPE_LENGTH'(3);
  localparam logic [OPCODE_TYPE_LENGTH-1:0] OP_HALT = OPCODE_TYPE_LENGTH'(4);
  localparam logic [ADDR_LENGTH-1:0]        PC_SEL  = ADDR_LENGTH'(PC_ADDR);

  state_t                          state_q, state_d;
  logic [OPCODE_TYPE_LENGTH-1:0]   op_type_q, op_type_d;
  logic [ALU_OPCODE_WIDTH-1:0]     alu_op_q, alu_op_d;
  logic [ADDR_LENGTH-1:0]          addr_a_q, addr_a_d;
  logic [ADDR_LENGTH-1:0]          addr_b_q, addr_b_d;
  logic                            mem_rdy;

`ifdef GB80_SEQ_WAIT_STATE_EN
  assign mem_rdy = i_mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = i_mem_ready;
  assign mem_rdy          = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_RESET;
      op_type_q <= '0;
      alu_op_q  <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_type_q <= op_type_d;
      alu_op_q  <= alu_op_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    op_type_d               = op_type_q;
    alu_op_d                = alu_op_q;
    addr_a_d                = addr_a_q;
    addr_b_d                = addr_b_q;
    o_register_file_addr    = '0;
    o_register_file_wr      = 1'b0;
    o_register_file_rd      = 1'b0;
    o_register_file_addr_wr = 1'b0;
    o_register_file_addr_rd = 1'b0;
    o_tmp_reg_wr            = 1'b0;
    o_tmp_reg_rd            = 1'b0;
    o_accumulator_reg_wr    = 1'b0;
    o_alu_control           = '0;
    o_alu_rd                = 1'b0;
    o_flags_reg_wr          = 1'b0;
    o_rd_mem                = 1'b0;
    o_wr_mem                = 1'b0;
    o_inst_reg_wr           = 1'b0;
    o_halted                = 1'b0;
    o_illegal               = 1'b0;

    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE:  state_d = S_F_PC_OUT;
      S_F_PC_OUT: begin
        o_rd_mem                = 1'b1;
        o_register_file_addr_rd = 1'b1;
        o_register_file_addr    = PC_SEL;
        if (mem_rdy) state_d = S_F_PC_INC;
      end
      S_F_PC_INC: begin
        o_register_file_addr_rd = 1'b1;
        o_register_file_addr_wr = 1'b1;
        o_register_file_addr    = PC_SEL;
        state_d                 = S_F_DECODE;
      end
      S_F_DECODE: begin
        o_inst_reg_wr = 1'b1;
        op_type_d     = i_opcode_type;
        alu_op_d      = i_alu_op;
        addr_a_d      = i_addr_A;
        addr_b_d      = i_addr_B;
        case (i_opcode_type)
          OP_LDRR: state_d = S_LDRR_TMP;
          OP_LDRI: state_d = S_LDRI_PC_OUT;
          OP_ALU:  state_d = S_ALU_TMP;
          OP_NOP:  state_d = S_F_PC_OUT;
          OP_HALT: state_d = S_HALT;
          default: begin
            o_illegal = 1'b1;
            state_d   = S_F_PC_OUT;
          end
        endcase
      end
      // Both operand-fetch states look the same; the latched class picks the second step.
      S_LDRR_TMP, S_ALU_TMP: begin
        o_register_file_addr = addr_b_q;
        o_register_file_rd   = 1'b1;
        o_tmp_reg_wr         = 1'b1;
        state_d              = (op_type_q == OP_ALU) ? S_ALU_EXEC : S_LDRR_WR;
      end
      S_LDRR_WR: begin
        o_register_file_addr = addr_a_q;
        o_tmp_reg_rd         = 1'b1;
        o_register_file_wr   = 1'b1;
        state_d              = S_F_PC_OUT;
      end
      // Immediate load: the memory data lands in A on the ready cycle, so select swaps PC -> A then.
      S_LDRI_PC_OUT: begin
        o_rd_mem                = 1'b1;
        o_register_file_addr_rd = 1'b1;
        o_register_file_addr    = PC_SEL;
        if (mem_rdy) begin
          o_register_file_wr   = 1'b1;
          o_register_file_addr = addr_a_q;
          state_d              = S_LDRI_PC_INC;
        end
      end
      S_LDRI_PC_INC: begin
        o_register_file_addr_rd = 1'b1;
        o_register_file_addr_wr = 1'b1;
        o_register_file_addr    = PC_SEL;
        state_d                 = S_F_PC_OUT;
      end
      S_ALU_EXEC: begin
        o_alu_control        = alu_op_q;
        o_alu_rd             = 1'b1;
        o_accumulator_reg_wr = 1'b1;
        o_flags_reg_wr       = 1'b1;
        state_d              = S_F_PC_OUT;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (i_wake) state_d = S_F_PC_OUT;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_gb80_sequencer.sv
// Directed bench for gb80_sequencer: per-cycle comparison of the full output vector against hand-written values.
module tb_gb80_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_opcode_type;
  logic [2:0] i_alu_op;
  logic [2:0] i_addr_A;
  logic [2:0] i_addr_B;
  logic       i_mem_ready;
  logic       i_wake;
  logic [2:0] o_register_file_addr;
  logic       o_register_file_wr, o_register_file_rd, o_register_file_addr_wr, o_register_file_addr_rd;
  logic       o_tmp_reg_wr, o_tmp_reg_rd, o_accumulator_reg_wr;
  logic [2:0] o_alu_control;
  logic       o_alu_rd, o_flags_reg_wr, o_rd_mem, o_wr_mem, o_inst_reg_wr, o_halted, o_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  gb80_sequencer #(
    .OPCODE_TYPE_LENGTH(4),
    .ALU_OPCODE_WIDTH  (3),
    .ADDR_LENGTH       (3),
    .PC_ADDR           (3)
  ) dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_opcode_type          (i_opcode_type),
    .i_alu_op               (i_alu_op),
    .i_addr_A               (i_addr_A),
    .i_addr_B               (i_addr_B),
    .i_mem_ready            (i_mem_ready),
    .i_wake                 (i_wake),
    .o_register_file_addr   (o_register_file_addr),
    .o_register_file_wr     (o_register_file_wr),
    .o_register_file_rd     (o_register_file_rd),
    .o_register_file_addr_wr(o_register_file_addr_wr),
    .o_register_file_addr_rd(o_register_file_addr_rd),
    .o_tmp_reg_wr           (o_tmp_reg_wr),
    .o_tmp_reg_rd           (o_tmp_reg_rd),
    .o_accumulator_reg_wr   (o_accumulator_reg_wr),
    .o_alu_control          (o_alu_control),
    .o_alu_rd               (o_alu_rd),
    .o_flags_reg_wr         (o_flags_reg_wr),
    .o_rd_mem               (o_rd_mem),
    .o_wr_mem               (o_wr_mem),
    .o_inst_reg_wr          (o_inst_reg_wr),
    .o_halted               (o_halted),
    .o_illegal              (o_illegal)
  );

  // Strobe mask bit positions within the 14-bit strobe field.
  localparam logic [13:0] RF_WR  = 14'h2000, RF_RD  = 14'h1000, RF_AWR = 14'h0800, RF_ARD  = 14'h0400;
  localparam logic [13:0] TMP_WR = 14'h0200, TMP_RD = 14'h0100, ACC_WR = 14'h0080, ALU_RD  = 14'h0040;
  localparam logic [13:0] FLG_WR = 14'h0020, RD_MEM = 14'h0010, WR_MEM = 14'h0008, IR_WR   = 14'h0004;
  localparam logic [13:0] HALTED = 14'h0002, ILLEGAL = 14'h0001;

  logic [19:0] obs;
  assign obs = {o_register_file_addr, o_alu_control,
                o_register_file_wr, o_register_file_rd, o_register_file_addr_wr, o_register_file_addr_rd,
                o_tmp_reg_wr, o_tmp_reg_rd, o_accumulator_reg_wr, o_alu_rd, o_flags_reg_wr,
                o_rd_mem, o_wr_mem, o_inst_reg_wr, o_halted, o_illegal};

  function automatic logic [19:0] ev(input logic [2:0] addr, input logic [2:0] alu, input logic [13:0] s);
    return {addr, alu, s};
  endfunction

  logic [19:0] E_ZERO, E_FPCOUT, E_FPCINC, E_DECODE, E_HALT;

  // Compare current outputs, then advance one clock and settle 1 time unit past the edge.
  task automatic cyc(input string tag, input logic [19:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    E_ZERO   = ev(3'd0, 3'd0, 14'd0);
    E_FPCOUT = ev(3'd3, 3'd0, RD_MEM | RF_ARD);
    E_FPCINC = ev(3'd3, 3'd0, RF_ARD | RF_AWR);
    E_DECODE = ev(3'd0, 3'd0, IR_WR);
    E_HALT   = ev(3'd0, 3'd0, HALTED);

    i_reset = 1'b1; i_opcode_type = 4'd3; i_alu_op = 3'd0;
    i_addr_A = 3'd0; i_addr_B = 3'd0; i_mem_ready = 1'b1; i_wake = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;

    // Reset release, NOP stream: IR write on cycle 4 then every 3 cycles.
    i_reset = 1'b0;
    cyc("reset_state", E_ZERO);
    cyc("idle", E_ZERO);
    for (int k = 0; k < 3; k++) begin
      cyc("nop_pc_out", E_FPCOUT);
      cyc("nop_pc_inc", E_FPCINC);
      cyc("nop_decode", E_DECODE);
    end

    // LD r,r' with A=2, B=5; live fields change to 7 after decode.
    i_opcode_type = 4'd0; i_addr_A = 3'd2; i_addr_B = 3'd5;
    cyc("ldrr_pc_out", E_FPCOUT);
    cyc("ldrr_pc_inc", E_FPCINC);
    cyc("ldrr_decode", E_DECODE);
    i_addr_A = 3'd7; i_addr_B = 3'd7; i_alu_op = 3'd7; i_opcode_type = 4'd3;
    cyc("ldrr_tmp", ev(3'd5, 3'd0, RF_RD | TMP_WR));
    cyc("ldrr_wr", ev(3'd2, 3'd0, TMP_RD | RF_WR));
    cyc("ldrr_next_fetch", E_FPCOUT);
    cyc("ldrr_next_inc", E_FPCINC);
    i_opcode_type = 4'd1; i_addr_A = 3'd4; i_addr_B = 3'd1;
    cyc("nop2_decode", E_DECODE);

    // The decode above was LD r,n with A=4.
    i_addr_A = 3'd7;
`ifdef GB80_SEQ_WAIT_STATE_EN
    i_mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc("ldri_wait", ev(3'd3, 3'd0, RD_MEM | RF_ARD));
    i_mem_ready = 1'b1;
    cyc("ldri_ready", ev(3'd4, 3'd0, RD_MEM | RF_ARD | RF_WR));
`else
    i_mem_ready = 1'b0;
    cyc("ldri_nowait", ev(3'd4, 3'd0, RD_MEM | RF_ARD | RF_WR));
`endif
    cyc("ldri_pc_inc", E_FPCINC);
    cyc("ldri_next_fetch", E_FPCOUT);
    i_mem_ready = 1'b1;

    // ALU op 3 from B=6; live op/B changed after decode.
    i_opcode_type = 4'd2; i_alu_op = 3'd3; i_addr_A = 3'd1; i_addr_B = 3'd6;
    cyc("alu_pc_inc", E_FPCINC);
    cyc("alu_decode", E_DECODE);
    i_alu_op = 3'd5; i_addr_B = 3'd0; i_opcode_type = 4'd3;
    cyc("alu_tmp", ev(3'd6, 3'd0, RF_RD | TMP_WR));
    cyc("alu_exec", ev(3'd0, 3'd3, ALU_RD | ACC_WR | FLG_WR));
    cyc("alu_next_fetch", E_FPCOUT);

    // Illegal opcode type 9: single-cycle pulse, then normal fetch.
    i_opcode_type = 4'd9;
    cyc("ill_pc_inc", E_FPCINC);
    cyc("ill_decode", ev(3'd0, 3'd0, IR_WR | ILLEGAL));
    i_opcode_type = 4'd3;
    cyc("ill_next_fetch", E_FPCOUT);
    cyc("ill_next_inc", E_FPCINC);
    i_opcode_type = 4'd4;
    cyc("halt_decode", E_DECODE);

    // HALT for 10 cycles, wake seen during the 10th.
    i_opcode_type = 4'd3;
    for (int k = 0; k < 9; k++) cyc("halted", E_HALT);
    i_wake = 1'b1;
    cyc("halted_wake", E_HALT);
    cyc("wake_fetch", E_FPCOUT);
    cyc("wake_ignored_inc", E_FPCINC);
    cyc("wake_ignored_dec", E_DECODE);
    i_wake = 1'b0;

    // Reset mid LD r,r'.
    i_opcode_type = 4'd0; i_addr_A = 3'd2; i_addr_B = 3'd5;
    cyc("rst_ldrr_pc_out", E_FPCOUT);
    cyc("rst_ldrr_pc_inc", E_FPCINC);
    cyc("rst_ldrr_decode", E_DECODE);
    i_reset = 1'b1;
    cyc("rst_ldrr_tmp", ev(3'd5, 3'd0, RF_RD | TMP_WR));
    cyc("rst_mid_ldrr", E_ZERO);
    i_reset = 1'b0;
    cyc("rst_release_reset", E_ZERO);
    cyc("rst_release_idle", E_ZERO);
    cyc("rst_release_fetch", E_FPCOUT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gb80_sequencer.md
GB80_SEQUENCER -- requirements
Module: gb80_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_TYPE_LENGTH, default 4, width of decoded opcode type.
REQ-002 SHALL have parameter ALU_OPCODE_WIDTH, default 3, width of ALU operation code.
REQ-003 SHALL have parameter ADDR_LENGTH, default 3 (minimum 3), width of register-file address.
REQ-004 SHALL have parameter PC_ADDR, default 3, register-file index of the program counter.
REQ-005 SHALL have ports:
- i_clk  in  1  clock, all state changes on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_opcode_type  in  OPCODE_TYPE_LENGTH  decoded instruction class.
- i_alu_op  in  ALU_OPCODE_WIDTH  decoded ALU operation.
- i_addr_A  in  ADDR_LENGTH  destination register.
- i_addr_B  in  ADDR_LENGTH  source register.
- i_mem_ready  in  1  memory access complete this cycle.
- i_wake  in  1  leave HALT.
- o_register_file_addr  out  ADDR_LENGTH  register select.
- o_register_file_wr, o_register_file_rd, o_register_file_addr_wr, o_register_file_addr_rd  out  1 each  register-file strobes.
- o_tmp_reg_wr, o_tmp_reg_rd, o_accumulator_reg_wr  out  1 each  ALU operand strobes.
- o_alu_control  out  ALU_OPCODE_WIDTH  ALU operation.
- o_alu_rd, o_flags_reg_wr  out  1 each  drive ALU result to bus; capture flags.
- o_rd_mem, o_wr_mem  out  1 each  memory strobes.
- o_inst_reg_wr  out  1  capture instruction register.
- o_halted  out  1  sequencer in HALT.
- o_illegal  out  1  one-cycle pulse on unknown opcode type.

Function
REQ-006 SHALL implement the states RESET, IDLE, F_PC_OUT, F_PC_INC, F_DECODE, LDRR_TMP, LDRR_WR, LDRI_PC_OUT, LDRI_PC_INC, ALU_TMP, ALU_EXEC and HALT.
REQ-007 SHALL decode opcode types as: 0 LD r,r'; 1 LD r,n; 2 ALU A,r; 3 NOP; 4 HALT; all other values illegal.
REQ-008 SHALL drive all outputs combinationally from state and latched fields, with every strobe 0 and every bus 0 in any state that does not name it.
REQ-009 SHALL follow RESET->IDLE->F_PC_OUT unconditionally.
REQ-010 F_PC_OUT SHALL assert o_rd_mem, o_register_file_addr_rd, and addr=PC_ADDR; it SHALL advance to F_PC_INC on i_mem_ready.
REQ-011 F_PC_INC SHALL assert o_register_file_addr_rd, o_register_file_addr_wr, and addr=PC_ADDR, then go to F_DECODE.
REQ-012 F_DECODE SHALL assert o_inst_reg_wr; it SHALL latch i_opcode_type, i_alu_op, i_addr_A and i_addr_B; it SHALL branch on i_opcode_type (0->LDRR_TMP, 1->LDRI_PC_OUT, 2->ALU_TMP, 3->F_PC_OUT, 4->HALT, illegal->F_PC_OUT with o_illegal=1).
REQ-013 All execute states SHALL use only the latched addr/alu fields, never the live inputs.
REQ-014 LDRR_TMP SHALL drive addr=B, o_register_file_rd and o_tmp_reg_wr; LDRR_WR SHALL drive addr=A, o_tmp_reg_rd and o_register_file_wr; LDRR_WR SHALL then go to F_PC_OUT.
REQ-015 LDRI_PC_OUT SHALL behave as F_PC_OUT and additionally drive o_register_file_wr with select=A while i_mem_ready=1; on i_mem_ready it SHALL go to LDRI_PC_INC (same outputs as F_PC_INC), then to F_PC_OUT.
REQ-016 ALU_TMP SHALL drive addr=B, o_register_file_rd and o_tmp_reg_wr; ALU_EXEC SHALL drive o_alu_control=latched op, o_alu_rd, o_accumulator_reg_wr and o_flags_reg_wr; ALU_EXEC SHALL then go to F_PC_OUT.
REQ-017 Cycle counts with zero wait states SHALL be NOP 3, LD r,r' 5, LD r,n 5, ALU 5.
REQ-018 HALT SHALL hold o_halted=1 and all strobes 0; on i_wake=1 it SHALL go to F_PC_OUT; i_wake SHALL be ignored in all other states.
REQ-019 Each cycle i_mem_ready=0 in a memory state SHALL hold that state and its outputs unchanged.
REQ-020 An undefined state encoding SHALL return to RESET on the next edge.

Reset
REQ-021 i_reset=1 on a rising edge SHALL force state RESET and clear latched fields, regardless of the current state, wait, or HALT.
REQ-022 In RESET, all outputs SHALL be 0, including o_halted and o_illegal.

Configuration
REQ-023 Macro GB80_SEQ_WAIT_STATE_EN defined: memory states SHALL stall on i_mem_ready per REQ-019.
REQ-024 Macro GB80_SEQ_WAIT_STATE_EN undefined: i_mem_ready SHALL be ignored and treated as 1, so every memory state lasts exactly one cycle.

Verification
REQ-025 Reset release, then NOP stream with i_mem_ready=1 -> o_inst_reg_wr pulses every 3 cycles, with the first pulse on cycle 4 after reset release.
REQ-026 LD r,r' with A=2, B=5, i_addr_* changed to 7 after F_DECODE -> LDRR_TMP addr=5 and LDRR_WR addr=2, o_register_file_wr exactly 1 cycle.
REQ-027 LD r,n with i_mem_ready low 3 cycles in LDRI_PC_OUT (macro on) -> instruction takes 8 cycles; o_register_file_wr is high only on the ready cycle, with addr=A.
REQ-028 ALU op=3 -> ALU_EXEC shows o_alu_control=3 with o_alu_rd, o_accumulator_reg_wr and o_flags_reg_wr all 1 for 1 cycle.
REQ-029 HALT then i_wake after 10 cycles -> o_halted=1 for 10 cycles; the next cycle is F_PC_OUT with o_rd_mem=1.
REQ-030 Opcode type 9 -> o_illegal pulses for 1 cycle and the next fetch follows; i_reset asserted mid-LDRR -> all outputs 0 the next cycle.
